mem_arb: RTL and testbench
==========================

# mem_arb

Parametrised byte-serial memory arbiter for the RISC-V core: the next-generation replacement for the two-port fetch/data memory controller. It serves NCH requester channels (channel 0 = instruction fetch, highest index = data stage by convention) over the single 8-bit synchronous RAM port, with per-channel req/ack handshakes, variable transfer size, abortable reads and selectable arbitration. It sits between the pipeline stages and the external RAM pins.

## Interface
- NCH, 2, number of requester channels (≥1)
- AW, 32, address width
- DW, 32, channel data width; multiple of 8; NB = DW/8 bytes
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  NCH  per-channel request; held high until ack
- kill  in  NCH  per-channel abort of an in-flight read
- wr  in  NCH  per-channel 1 = write, 0 = read
- addr  in  NCH*AW  per-channel start byte address
- sz  in  NCH*clog2(NB)  per-channel byte count minus one
- wdata  in  NCH*DW  per-channel write data, little-endian
- ack  out  NCH  one-cycle completion pulse
- rdata  out  DW  read data, zero-extended, valid with ack
- busy  out  1  transfer in progress (state ≠ IDLE)
- rom_rn  in  8  RAM read byte, valid one cycle after rom_a
- rom_wn  out  8  RAM write byte
- rom_a  out  AW  RAM byte address
- rom_wr  out  1  RAM write strobe

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: no req → stay. Any req → at edge latch winning channel, its addr/wr/sz/wdata; cnt=0; → BUSY.
- BUSY, cnt=k, n=sz+1:
  - write: rom_a=addr+k, rom_wn=wdata byte k, rom_wr=1; at k=n-1 → DONE.
  - read: for k<n, rom_a=addr+k, rom_wr=0; for k≥1 capture rom_rn into byte k-1 at edge; at k=n capture byte n-1 → DONE (rom_a holds addr+n-1).
- DONE: ack[ch]=1, rdata valid; → IDLE. Requester drops req at this edge.
- Address arithmetic modulo 2^AW (wrap from all-ones to 0).
- Unread upper bytes of rdata are 0; sign extension belongs to the requester.
- kill[ch] high in BUSY on a read of ch → IDLE at next edge, no ack, rdata unchanged. Kill coincident with the final capture edge: abort wins. Kill on a write, or in IDLE/DONE, is ignored.
- req of the active channel dropped early: undefined requester error; arbiter completes the transfer anyway.
- rdata holds its last acked value until the next ack.

## Timing
- Reset: state IDLE, ack=0, rdata=0, busy=0, rom_a=0, rom_wn=0, rom_wr=0, cnt=0, RR pointer=NCH-1. Asynchronous reset mid-transfer clears rom_wr immediately.
- req seen in cycle 0 → write of n bytes: ack in cycle n+1; read of n bytes: ack in cycle n+2.
- Back-to-back: at least one IDLE cycle between DONE and the next grant.
- Outputs rom_* are registered-state-derived (no combinational path from req).

## Configuration
- MEM_ARB_RR_EN defined: round-robin grant; search starts at (last granted + 1) mod NCH, pointer updates on grant.
- Undefined: fixed priority, highest channel index wins (data over fetch).

## Structure
- Package mem_arb_pkg: state enum (IDLE/BUSY/DONE), helper localparams NB and SZW=clog2(NB).
- Sub-module mem_arb_sel: combinational grant selector (fixed or RR under MEM_ARB_RR_EN), inputs req vector and pointer, output one-hot grant and index.

## Test plan
- Ch0 read, addr 0x100, sz=3, RAM bytes 11 22 33 44 → ack[0] in cycle 6, rdata 0x44332211; rom_a sequence 0x100..0x103.
- Ch1 write, addr 0xFFFFFFFE, sz=3, wdata 0xA1B2C3D4 → rom_wr 4 cycles, rom_a FFFFFFFE, FFFFFFFF, 0, 1, rom_wn D4 C3 B2 A1; ack[1] in cycle 5.
- Ch0 and ch1 req together (sz=0 reads), held: fixed priority → ch1 then ch0; with MEM_ARB_RR_EN after reset → ch0 then ch1.
- Ch0 read sz=3, kill[0] at cnt=2 → IDLE next cycle, no ack, rdata unchanged; kill[1] during a write → write completes, ack issued.
- Assert rst low at cnt=1 of a write → rom_wr 0 immediately, busy 0; after release, new sz=1 read acks in cycle 4 with rdata 0x0000xxxx upper bytes 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the byte-serial memory arbiter.
package mem_arb_pkg;

    // Transfer sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bytes per channel word and byte-count field width for the default 32-bit channel
    localparam int unsigned NB  = 32 / 8;
    localparam int unsigned SZW = $clog2(NB);

    // Bit width for an index/count field, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant selector: fixed priority (highest index wins) by default,
// round-robin starting after the last granted channel when MEM_ARB_RR_EN is defined.
module mem_arb_sel
    import mem_arb_pkg::*;
#(
    parameter  int unsigned NCH = 2,
    localparam int unsigned IW  = clog2_min1(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx
);

    logic          any;
    logic [IW-1:0] cand;

`ifdef MEM_ARB_RR_EN
    // Round-robin search beginning at (ptr + 1) mod NCH
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = IW'((32'(ptr) + i + 32'd1) % NCH);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
`else
    logic [IW-1:0] unused_ptr;
    assign unused_ptr = ptr;

    // Fixed priority: later (higher) channels override lower ones
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = IW'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
`endif

    // One-hot form of the selected index
    always_comb begin
        gnt = '0;
        if (any) begin
            gnt = NCH'(1) << idx;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Byte-serial arbiter: serves NCH req/ack channels over one 8-bit synchronous RAM port.
// Define MEM_ARB_RR_EN for round-robin grants; default is fixed priority (highest index).
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter  int unsigned NCH   = 2,
    parameter  int unsigned AW    = 32,
    parameter  int unsigned DW    = 32,
    localparam int unsigned NB_L  = DW / 8,
    localparam int unsigned SZW_L = clog2_min1(NB_L),
    localparam int unsigned IW    = clog2_min1(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req,
    input  logic [NCH-1:0]       kill,
    input  logic [NCH-1:0]       wr,
    input  logic [NCH*AW-1:0]    addr,
    input  logic [NCH*SZW_L-1:0] sz,
    input  logic [NCH*DW-1:0]    wdata,
    output logic [NCH-1:0]       ack,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    input  logic [7:0]           rom_rn,
    output logic [7:0]           rom_wn,
    output logic [AW-1:0]        rom_a,
    output logic                 rom_wr
);

    // Counter holds 0..NB_L, one bit wider than the size field
    localparam int unsigned CW = SZW_L + 1;

    logic [AW-1:0]    addr_a  [NCH];
    logic [SZW_L-1:0] sz_a    [NCH];
    logic [DW-1:0]    wdata_a [NCH];

    // Split flat per-channel buses into arrays
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign addr_a[g]  = addr[g*AW +: AW];
        assign sz_a[g]    = sz[g*SZW_L +: SZW_L];
        assign wdata_a[g] = wdata[g*DW +: DW];
    end

    state_e        state_q, state_d;
    logic [IW-1:0] ch_q, ch_d;
    logic          wr_q, wr_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] wsh_q, wsh_d;
    logic [DW-1:0] rbuf_q, rbuf_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] rom_a_q, rom_a_d;
    logic [7:0]    rom_wn_q, rom_wn_d;
    logic          rom_wr_q, rom_wr_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [NCH-1:0] gnt_c;
    logic [IW-1:0]  gidx_c;

    mem_arb_sel #(
        .NCH (NCH)
    ) u_sel (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt_c),
        .idx (gidx_c)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        wr_d     = wr_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        wsh_d    = wsh_q;
        rbuf_d   = rbuf_q;
        rdata_d  = rdata_q;
        ack_d    = '0;
        rom_a_d  = rom_a_q;
        rom_wn_d = rom_wn_q;
        rom_wr_d = rom_wr_q;
        ptr_d    = ptr_q;

        case (state_q)
            IDLE: begin
                rom_wr_d = 1'b0;
                if (|gnt_c) begin
                    state_d  = BUSY;
                    ch_d     = gidx_c;
                    wr_d     = wr[gidx_c];
                    n_d      = CW'(sz_a[gidx_c]) + CW'(1);
                    cnt_d    = '0;
                    rbuf_d   = '0;
                    rom_a_d  = addr_a[gidx_c];
                    rom_wr_d = wr[gidx_c];
                    rom_wn_d = wdata_a[gidx_c][7:0];
                    wsh_d    = wdata_a[gidx_c] >> 8;
                    ptr_d    = gidx_c;
                end
            end
            BUSY: begin
                if (wr_q) begin
                    if (cnt_q == n_q - CW'(1)) begin
                        state_d    = DONE;
                        rom_wr_d   = 1'b0;
                        ack_d[ch_q] = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + CW'(1);
                        rom_a_d  = rom_a_q + AW'(1);
                        rom_wn_d = wsh_q[7:0];
                        wsh_d    = wsh_q >> 8;
                    end
                end else if (kill[ch_q]) begin
                    // Abort takes priority, even on the final capture edge
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // RAM byte for address addr+cnt-1 is on rom_rn now
                    if (cnt_q != '0) begin
                        for (int unsigned b = 0; b < NB_L; b++) begin
                            if (cnt_q - CW'(1) == CW'(b)) begin
                                rbuf_d[b*8 +: 8] = rom_rn;
                            end
                        end
                    end
                    if (cnt_q == n_q) begin
                        state_d     = DONE;
                        rdata_d     = rbuf_d;
                        ack_d[ch_q] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) < n_q) begin
                            rom_a_d = rom_a_q + AW'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d  = IDLE;
                rom_wr_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            wr_q     <= 1'b0;
            n_q      <= '0;
            cnt_q    <= '0;
            wsh_q    <= '0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            rom_a_q  <= '0;
            rom_wn_q <= '0;
            rom_wr_q <= 1'b0;
            ptr_q    <= IW'(NCH - 1);
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            wr_q     <= wr_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            wsh_q    <= wsh_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            rom_a_q  <= rom_a_d;
            rom_wn_q <= rom_wn_d;
            rom_wr_q <= rom_wr_d;
            ptr_q    <= ptr_d;
        end
    end

    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign rom_a  = rom_a_q;
    assign rom_wn = rom_wn_q;
    assign rom_wr = rom_wr_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb (NCH=2, AW=32, DW=32) with a byte RAM model on the rom_* pins.
module tb_mem_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req, kill, wr;
    logic [63:0] addr;
    logic [3:0]  sz;
    logic [63:0] wdata;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  rom_rn, rom_wn;
    logic [31:0] rom_a;
    logic        rom_wr;

    logic [31:0] a_ch [2];
    logic [1:0]  s_ch [2];
    logic [31:0] w_ch [2];
    logic [7:0]  mem  [256];

    int total = 0;
    int bad   = 0;

    assign addr  = {a_ch[1], a_ch[0]};
    assign sz    = {s_ch[1], s_ch[0]};
    assign wdata = {w_ch[1], w_ch[0]};

    mem_arb #(.NCH(2), .AW(32), .DW(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .kill   (kill),
        .wr     (wr),
        .addr   (addr),
        .sz     (sz),
        .wdata  (wdata),
        .ack    (ack),
        .rdata  (rdata),
        .busy   (busy),
        .rom_rn (rom_rn),
        .rom_wn (rom_wn),
        .rom_a  (rom_a),
        .rom_wr (rom_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: read data one cycle after address, write on strobe
    always @(posedge clk) begin
        rom_rn <= mem[rom_a[7:0]];
        if (rom_wr) mem[rom_a[7:0]] <= rom_wn;
    end

    typedef struct {
        bit          ch;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [31:0] wdata;
        int          ack_cyc;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One transaction starting in cycle 0; checks pins per cycle and the ack
    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] ea, ew;
        logic [1:0]  eack;
        int          n;
        bit          got;
        n    = int'(v.sz) + 1;
        eack = v.ch ? 2'b10 : 2'b01;
        wr[v.ch]   = v.wr;
        a_ch[v.ch] = v.addr;
        s_ch[v.ch] = v.sz;
        w_ch[v.ch] = v.wdata;
        req[v.ch]  = 1'b1;
        got = 1'b0;
        for (int c = 1; c <= 24 && !got; c++) begin
            @(posedge clk); #1;
            if (c == 1) chk({nm, ".busy"}, 32'(busy), 32'd1);
            if (c <= n) begin
                ea = v.addr + 32'(c - 1);
                chk($sformatf("%s.rom_a%0d", nm, c), rom_a, ea);
                chk($sformatf("%s.rom_wr%0d", nm, c), 32'(rom_wr), 32'(v.wr));
                if (v.wr) begin
                    ew = v.wdata >> (8 * (c - 1));
                    chk($sformatf("%s.rom_wn%0d", nm, c), 32'(rom_wn), 32'(ew[7:0]));
                end
            end else if (!v.wr && c == n + 1) begin
                chk({nm, ".rom_a_hold"}, rom_a, v.addr + 32'(n - 1));
            end
            if (ack != 2'b00) begin
                got = 1'b1;
                chk({nm, ".ack_cycle"}, 32'(c), 32'(v.ack_cyc));
                chk({nm, ".ack"}, 32'(ack), 32'(eack));
                if (!v.wr) chk({nm, ".rdata"}, rdata, v.rdata);
            end
        end
        req[v.ch] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s.timeout got=no_ack want=ack", nm);
        end
        @(posedge clk); #1;
        chk({nm, ".ack_clr"}, 32'(ack), 32'd0);
        chk({nm, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0; kill = '0; wr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=stuck want=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  exp_first, exp_second;
        logic [31:0] exp_rd1, exp_rd2;
        int          phase;
        vec_t        rv;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
        mem[8'h20] = 8'h77; mem[8'h21] = 8'h88;
        for (int i = 0; i < 2; i++) begin
            a_ch[i] = '0; s_ch[i] = '0; w_ch[i] = '0;
        end

        //            ch    wr    addr           sz    wdata          ack  rdata
        vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 2'd3, 32'h0,         6, 32'h4433_2211};
        vt[1] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 2'd3, 32'hA1B2_C3D4, 5, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0002, 2'd1, 32'h0,         4, 32'h0000_4433};
        vt[3] = '{1'b0, 1'b1, 32'h0000_0010, 2'd0, 32'h0000_005A, 2, 32'h0};
        vt[4] = '{1'b0, 1'b0, 32'h0000_0010, 2'd0, 32'h0,         3, 32'h0000_005A};
        vt[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 2'd2, 32'h0,         5, 32'h00A1_B2C3};

        // Reset values, checked while reset is asserted
        rst = 1'b0;
        req = '0; kill = '0; wr = '0;
        #2;
        chk("rst.ack",    32'(ack),    32'd0);
        chk("rst.rdata",  rdata,       32'd0);
        chk("rst.busy",   32'(busy),   32'd0);
        chk("rst.rom_a",  rom_a,       32'd0);
        chk("rst.rom_wn", 32'(rom_wn), 32'd0);
        chk("rst.rom_wr", 32'(rom_wr), 32'd0);
        do_reset();

        // Simultaneous single-byte reads on both channels, held until acked
`ifdef MEM_ARB_RR_EN
        exp_first = 2'b01; exp_second = 2'b10; exp_rd1 = 32'h77; exp_rd2 = 32'h88;
`else
        exp_first = 2'b10; exp_second = 2'b01; exp_rd1 = 32'h88; exp_rd2 = 32'h77;
`endif
        a_ch[0] = 32'h20; a_ch[1] = 32'h21; s_ch[0] = 2'd0; s_ch[1] = 2'd0;
        wr = 2'b00; req = 2'b11;
        phase = 0;
        for (int c = 1; c <= 30 && phase < 2; c++) begin
            @(posedge clk); #1;
            if (ack != 2'b00) begin
                if (phase == 0) begin
                    chk("arb.first_ack",   32'(ack), 32'(exp_first));
                    chk("arb.first_cycle", 32'(c),   32'd3);
                    chk("arb.first_rdata", rdata,    exp_rd1);
                    req = req & ~exp_first;
                end else begin
                    chk("arb.second_ack",   32'(ack), 32'(exp_second));
                    chk("arb.second_cycle", 32'(c),   32'd7);
                    chk("arb.second_rdata", rdata,    exp_rd2);
                    req = 2'b00;
                end
                phase++;
            end
        end
        if (phase < 2) begin
            total++; bad++;
            $display("FAIL arb.timeout got=%0d want=2", phase);
        end
        req = 2'b00;
        @(posedge clk); #1;

        // Table-driven transfers
        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));
        chk("vec1.mem_fe", 32'(mem[8'hFE]), 32'hD4);
        chk("vec1.mem_01", 32'(mem[8'h01]), 32'hA1);

        // Kill of a ch0 read at cnt=2: no ack, rdata keeps previous value
        wr[0] = 1'b0; a_ch[0] = 32'h100; s_ch[0] = 2'd3; req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req[0] = 1'b0; kill[0] = 1'b1;
        @(posedge clk); #1;
        kill[0] = 1'b0;
        chk("kill.busy", 32'(busy), 32'd0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("kill.no_ack%0d", c), 32'(ack), 32'd0);
            @(posedge clk); #1;
        end
        chk("kill.rdata", rdata, vt[5].rdata);

        // Kill on a write is ignored
        kill[1] = 1'b1;
        rv = '{1'b1, 1'b1, 32'h30, 2'd1, 32'h0000_BEEF, 3, 32'h0};
        run_vec(rv, "killwr");
        kill[1] = 1'b0;
        chk("killwr.mem30", 32'(mem[8'h30]), 32'hEF);
        chk("killwr.mem31", 32'(mem[8'h31]), 32'hBE);

        // Reset asserted at cnt=1 of a write
        wr[1] = 1'b1; a_ch[1] = 32'h40; s_ch[1] = 2'd3; w_ch[1] = 32'h1234_5678; req[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid.rom_wr_before", 32'(rom_wr), 32'd1);
        rst = 1'b0;
        req = 2'b00;
        #1;
        chk("rstmid.rom_wr", 32'(rom_wr), 32'd0);
        chk("rstmid.busy",   32'(busy),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rv = '{1'b0, 1'b0, 32'h0, 2'd1, 32'h0, 4, 32'h0000_A1B2};
        run_vec(rv, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
